// File: rtl/exec_flag_stage_pkg.sv
// Shared definitions for the execute-stage back end.
//   - Datapath widths used as parameter defaults by the interface and the top.
//   - 5-bit opcode constants.
//   - Bit positions of ZF/NF/CF inside the packed flag vector.
//   - Run/halt FSM state encoding.
//   - Opcode-class helpers: which ops set flags, and which write the register file.
package exec_flag_stage_pkg;

    localparam int unsigned DataWidth    = 16;
    localparam int unsigned OpWidth      = 5;
    localparam int unsigned RegAddrWidth = 3;

    typedef logic [OpWidth-1:0] opcode_t;

    localparam opcode_t OpNop   = 5'd0;
    localparam opcode_t OpHalt  = 5'd1;
    localparam opcode_t OpLoad  = 5'd2;
    localparam opcode_t OpStore = 5'd3;
    localparam opcode_t OpLdih  = 5'd4;
    localparam opcode_t OpAdd   = 5'd5;
    localparam opcode_t OpAddi  = 5'd6;
    localparam opcode_t OpAddc  = 5'd7;
    localparam opcode_t OpSub   = 5'd8;
    localparam opcode_t OpSubi  = 5'd9;
    localparam opcode_t OpSubc  = 5'd10;
    localparam opcode_t OpCmp   = 5'd11;
    localparam opcode_t OpAnd   = 5'd12;
    localparam opcode_t OpOr    = 5'd13;
    localparam opcode_t OpXor   = 5'd14;
    localparam opcode_t OpSll   = 5'd15;
    localparam opcode_t OpSla   = 5'd16;
    localparam opcode_t OpSrl   = 5'd17;
    localparam opcode_t OpSra   = 5'd18;
    localparam opcode_t OpJump  = 5'd19;
    localparam opcode_t OpJmpr  = 5'd20;
    localparam opcode_t OpBz    = 5'd21;
    localparam opcode_t OpBnz   = 5'd22;
    localparam opcode_t OpBn    = 5'd23;
    localparam opcode_t OpBnn   = 5'd24;
    localparam opcode_t OpBc    = 5'd25;
    localparam opcode_t OpBnc   = 5'd26;
    // 27..31 are unassigned and behave as NOP.

    // Flag vector layout: {ZF, NF, CF}
    localparam int unsigned FlagCIdx = 0;
    localparam int unsigned FlagNIdx = 1;
    localparam int unsigned FlagZIdx = 2;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StRun    = 2'd1,
        StHalted = 2'd2
    } state_e;

    // Arithmetic, compare, logic and shift ops update {ZF, NF, CF}.
    function automatic logic op_sets_flags(input opcode_t op);
        return op inside {OpAdd, OpAddi, OpAddc, OpSub, OpSubi, OpSubc, OpCmp,
                          OpAnd, OpOr, OpXor, OpSll, OpSla, OpSrl, OpSra};
    endfunction

    // Ops that produce a register-file write in the write-back stage.
    function automatic logic op_writes_reg(input opcode_t op);
        return op inside {OpLoad, OpLdih, OpAdd, OpAddi, OpAddc, OpSub, OpSubi,
                          OpSubc, OpAnd, OpOr, OpXor, OpSll, OpSla, OpSrl, OpSra};
    endfunction

endpackage

// File: rtl/exec_flag_stage_if.sv
// EX-side inputs and EX/MEM-side outputs of the execute back end, bundled.
//   master: upstream/control side (drives EX slot, ALU result, enable/stall).
//   slave : the exec_flag_stage itself (drives flags, redirect, EX/MEM, halted).
interface exec_flag_stage_if
    import exec_flag_stage_pkg::*;
#(
    parameter int unsigned DATA_W = DataWidth,
    parameter int unsigned OP_W   = OpWidth,
    parameter int unsigned REG_AW = RegAddrWidth
);
    // Control and EX slot
    logic              enable;
    logic              stall;
    logic              ex_valid;
    logic [OP_W-1:0]   ex_op;
    logic [REG_AW-1:0] ex_dest;
    logic [DATA_W-1:0] ex_store_data;
    logic [DATA_W-1:0] alu_out;
    logic              alu_cf;

    // Flags and redirect
    logic              cf_to_alu;
    logic              flag_zf;
    logic              flag_nf;
    logic              flag_cf;
    logic              br_taken;
    logic [DATA_W-1:0] br_target;

    // EX/MEM register and status
    logic              mem_valid;
    logic [OP_W-1:0]   mem_op;
    logic [DATA_W-1:0] mem_result;
    logic [DATA_W-1:0] mem_store_data;
    logic [REG_AW-1:0] mem_dest;
    logic              mem_we;
    logic              mem_reg_we;
    logic              halted;

    modport master (
        output enable, stall, ex_valid, ex_op, ex_dest, ex_store_data, alu_out, alu_cf,
        input  cf_to_alu, flag_zf, flag_nf, flag_cf, br_taken, br_target,
        input  mem_valid, mem_op, mem_result, mem_store_data, mem_dest, mem_we,
        input  mem_reg_we, halted
    );

    modport slave (
        input  enable, stall, ex_valid, ex_op, ex_dest, ex_store_data, alu_out, alu_cf,
        output cf_to_alu, flag_zf, flag_nf, flag_cf, br_taken, br_target,
        output mem_valid, mem_op, mem_result, mem_store_data, mem_dest, mem_we,
        output mem_reg_we, halted
    );

endinterface

// File: rtl/exec_flag_stage_branch_cond.sv
// Branch condition decode (combinational).
//   op_i    : opcode in EX
//   flags_i : committed flag register {ZF, NF, CF}
//   taken_o : 1 when the op redirects given those flags (unconditional for jumps)
module exec_flag_stage_branch_cond
    import exec_flag_stage_pkg::*;
(
    input  opcode_t    op_i,
    input  logic [2:0] flags_i,
    output logic       taken_o
);

    always_comb begin
        taken_o = 1'b0;
        case (op_i)
            OpJump, OpJmpr: taken_o = 1'b1;
            OpBz:           taken_o = flags_i[FlagZIdx];
            OpBnz:          taken_o = ~flags_i[FlagZIdx];
            OpBn:           taken_o = flags_i[FlagNIdx];
            OpBnn:          taken_o = ~flags_i[FlagNIdx];
            OpBc:           taken_o = flags_i[FlagCIdx];
            OpBnc:          taken_o = ~flags_i[FlagCIdx];
            default:        taken_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/exec_flag_stage.sv
// Execute-stage back end, downstream of the combinational ALU.
//   clock, reset : single clock; synchronous active-high reset
//   bus (slave)  : enable/stall control, EX slot (valid, op, dest, store data),
//                  ALU result/carry in; flag register, cf_to_alu feedback, branch
//                  redirect (br_taken/br_target), EX/MEM register and halted out.
// Owns the {ZF, NF, CF} flag register, resolves jumps/branches against the
// committed flags, holds the EX/MEM pipeline register and the run/halt FSM.
module exec_flag_stage
    import exec_flag_stage_pkg::*;
#(
    parameter int unsigned DATA_W = DataWidth,
    parameter int unsigned OP_W   = OpWidth,
    parameter int unsigned REG_AW = RegAddrWidth
) (
    input logic               clock,
    input logic               reset,
    exec_flag_stage_if.slave  bus
);

    state_e            state_q;
    logic              halted_q;
    logic [2:0]        flags_q;

    logic              mem_valid_q;
    logic [OP_W-1:0]   mem_op_q;
    logic [DATA_W-1:0] mem_result_q;
    logic [DATA_W-1:0] mem_store_data_q;
    logic [REG_AW-1:0] mem_dest_q;
    logic              mem_we_q;
    logic              mem_reg_we_q;

    logic              accept;
    logic              cond_taken;

    // An EX instruction is consumed only while running, unstalled and valid.
    // Reset is folded in so the redirect is quiet during a reset cycle.
    assign accept = ~reset && (state_q == StRun) && ~bus.stall && bus.ex_valid;

    exec_flag_stage_branch_cond u_branch_cond (
        .op_i    (bus.ex_op),
        .flags_i (flags_q),
        .taken_o (cond_taken)
    );

    // Run/halt FSM; halted is registered alongside the state.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= StIdle;
            halted_q <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus.enable) begin
                        state_q <= StRun;
                    end
                end
                StRun: begin
                    if (accept && (bus.ex_op == OpHalt)) begin
                        state_q  <= StHalted;
                        halted_q <= 1'b1;
                    end
                end
                StHalted: begin
                    state_q <= StHalted;
                end
                default: begin
                    state_q  <= StIdle;
                    halted_q <= 1'b0;
                end
            endcase
        end
    end

    // Flag register: only accepted flag-setting ops update it.
    always_ff @(posedge clock) begin
        if (reset) begin
            flags_q <= 3'b000;
        end else if (accept && op_sets_flags(bus.ex_op)) begin
            flags_q[FlagZIdx] <= (bus.alu_out == '0);
            flags_q[FlagNIdx] <= bus.alu_out[DATA_W-1];
            flags_q[FlagCIdx] <= bus.alu_cf;
        end
    end

    // EX/MEM register: bubble outside RUN, hold on stall, bubble on an empty slot.
    always_ff @(posedge clock) begin
        if (reset || (state_q != StRun) || (~bus.stall && ~bus.ex_valid)) begin
            mem_valid_q      <= 1'b0;
            mem_op_q         <= OpNop;
            mem_result_q     <= '0;
            mem_store_data_q <= '0;
            mem_dest_q       <= '0;
            mem_we_q         <= 1'b0;
            mem_reg_we_q     <= 1'b0;
        end else if (~bus.stall) begin
            mem_valid_q      <= 1'b1;
            mem_op_q         <= bus.ex_op;
            mem_result_q     <= bus.alu_out;
            mem_store_data_q <= bus.ex_store_data;
            mem_dest_q       <= bus.ex_dest;
            mem_we_q         <= (bus.ex_op == OpStore);
            mem_reg_we_q     <= op_writes_reg(bus.ex_op);
        end
    end

    assign bus.cf_to_alu      = flags_q[FlagCIdx];
    assign bus.flag_zf        = flags_q[FlagZIdx];
    assign bus.flag_nf        = flags_q[FlagNIdx];
    assign bus.flag_cf        = flags_q[FlagCIdx];
    assign bus.br_taken       = accept & cond_taken;
    assign bus.br_target      = bus.alu_out;
    assign bus.mem_valid      = mem_valid_q;
    assign bus.mem_op         = mem_op_q;
    assign bus.mem_result     = mem_result_q;
    assign bus.mem_store_data = mem_store_data_q;
    assign bus.mem_dest       = mem_dest_q;
    assign bus.mem_we         = mem_we_q;
    assign bus.mem_reg_we     = mem_reg_we_q;
    assign bus.halted         = halted_q;

endmodule

// File: doc/exec_flag_stage.md
Name: exec_flag_stage

Overview:
Execute-stage back end, directly downstream of the combinational ALU. It consumes the ALU result and carry for the instruction in EX and owns the architectural flag register {ZF, NF, CF}, feeding CF back to the ALU as cf_in. It resolves jumps and branches and drives the PC redirect. It holds the EX/MEM pipeline register that feeds the memory stage, and it implements the run/halt control FSM.

Parameters:
DATA_W, 16, datapath width (ALU result, store data, branch target)
OP_W, 5, opcode width
REG_AW, 3, register-file address width

Ports:
clock  in  1  single clock; all state updates on its rising edge
reset  in  1  synchronous, active-high; sampled on rising edge of clock
enable  in  1  start request; moves the FSM out of IDLE
stall  in  1  hazard-unit hold; freezes this stage for the cycle
ex_valid  in  1  EX slot holds a real instruction (0 = bubble)
ex_op  in  OP_W  opcode of the instruction in EX
ex_dest  in  REG_AW  destination register of the instruction in EX
ex_store_data  in  DATA_W  rs data for STORE
alu_out  in  DATA_W  ALU result (address, result or branch target)
alu_cf  in  1  ALU carry/borrow out
cf_to_alu  out  1  registered CF, drives the ALU cf_in
flag_zf, flag_nf, flag_cf  out  1 each  flag register
br_taken  out  1  redirect PC this cycle; upstream flushes IF/ID
br_target  out  DATA_W  redirect address
mem_valid  out  1  EX/MEM holds a real instruction
mem_op  out  OP_W  registered opcode
mem_result  out  DATA_W  registered alu_out (data or address)
mem_store_data  out  DATA_W  registered ex_store_data
mem_dest  out  REG_AW  registered ex_dest
mem_we  out  1  data-memory write (STORE only)
mem_reg_we  out  1  write-back enable
halted  out  1  FSM in HALTED

Behaviour:
- Reset dominates every other input. On reset the FSM goes to IDLE. Flags are 0, cf_to_alu is 0, and all mem_* outputs are 0 (mem_op = NOP). halted is 0.
- FSM states:
  - IDLE goes to RUN when enable=1.
  - RUN goes to HALTED on an edge where a valid HALT is accepted (ex_valid=1, stall=0, ex_op=HALT).
  - HALTED is sticky until reset.
- In IDLE and HALTED: the flags hold, br_taken=0, and EX/MEM loads a bubble (all mem_* fields 0).
- "accept" means FSM=RUN, stall=0 and ex_valid=1.
- On accept, EX/MEM loads op, alu_out, store data and dest with a latency of 1 cycle.
  - mem_we=1 only for STORE.
  - mem_reg_we=1 for LOAD, LDIH, ADD, ADDI, ADDC, SUB, SUBI, SUBC, AND, OR, XOR, SLL, SLA, SRL, SRA.
  - mem_reg_we=0 for CMP, STORE, JUMP, JMPR, Bxx, NOP and HALT.
- In RUN with ex_valid=0, EX/MEM loads a bubble.
- In RUN with stall=1, EX/MEM holds its previous contents, the flags hold and br_taken=0.
- Flag update on accept of a flag-setting op (arithmetic, CMP, logic, shifts):
  - ZF = (alu_out == 0)
  - NF = alu_out[15]
  - CF = alu_cf
- LOAD, STORE, LDIH, jumps, branches, NOP and HALT leave the flags unchanged.
- cf_to_alu = flag_cf (registered value only; there is no combinational bypass).
- Branch resolution is combinational in the same cycle as the instruction in EX and is gated by accept.
  - It uses the flag register, i.e. the flags produced by the most recent flag-setting instruction, which committed on an earlier edge.
  - JUMP and JMPR are always taken.
  - BZ is taken if ZF, BNZ if !ZF, BN if NF, BNN if !NF, BC if CF, BNC if !CF.
  - br_target = alu_out at all times. It is meaningful only when br_taken=1.
- A taken branch still enters EX/MEM as a non-writing instruction, so mem_valid=1.
- All arithmetic is modulo 2^16. The carry comes only from alu_cf; it is never recomputed here.
- Unknown opcodes are treated as NOP: no flag change, no writes, not taken.

Decomposition:
- Shared package/header holds:
  - 5-bit opcode constants (NOP, HALT, LOAD, STORE, LDIH, ADD, ADDI, ADDC, SUB, SUBI, SUBC, CMP, AND, OR, XOR, SLL, SLA, SRL, SRA, JUMP, JMPR, BZ, BNZ, BN, BNN, BC, BNC).
  - Flag bit indices.
  - FSM state encodings (IDLE, RUN, HALTED).
- One sub-module, branch_cond: combinational. Inputs are opcode and the flags; output is taken. It is reused by the verification model.

Test Plan:
- Reset then enable: assert reset for 2 cycles, then enable=1 -> all outputs 0 during reset; FSM is RUN on the edge after enable; a NOP gives mem_valid=1 with mem_reg_we=0.
- Flags via CMP: CMP with alu_out=0x0000, alu_cf=0, then BZ with alu_out=0x0040 -> ZF=1 after the CMP edge; in the BZ cycle br_taken=1 and br_target=0x0040. Repeat with alu_out=0x8001 before BN -> NF=1 and BN taken.
- Carry feedback: ADD with alu_cf=1 -> cf_to_alu=1 on the next cycle; an intervening LOAD leaves it at 1; AND with alu_cf=0 clears it.
- Stall: hold stall=1 for 3 cycles while a taken BNZ sits in EX -> br_taken=0, mem_* and flags unchanged; on release br_taken=1 for exactly one cycle.
- STORE/write-back: STORE with alu_out=0x0123 and ex_store_data=0xBEEF -> next cycle mem_we=1, mem_result=0x0123, mem_store_data=0xBEEF, mem_reg_we=0.
- Halt: HALT accepted -> halted=1 on the next edge; subsequent valid ADDs produce bubbles and no flag change; synchronous reset mid-HALTED returns to IDLE with all outputs 0.
